// File: rtl/dsp_sched_pkg.sv
// Shared definitions for the DSP48A1 MAC scheduler: FSM states and opmode codes.
package dsp_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFin
    } state_e;

    // Opmode codes as seen by the P register: MUL = (Z=0, X=M), MAC = (Z=P, X=M), HOLD = (Z=P, X=0)
    localparam logic [7:0] OPM_MUL  = 8'h01;
    localparam logic [7:0] OPM_MAC  = 8'h09;
    localparam logic [7:0] OPM_HOLD = 8'h08;

endpackage

// File: rtl/dsp_mac_sched_opm_pipe.sv
// Opmode delay line: lines each per-beat opmode code up with its product at the P-register input.
module opm_pipe
    import dsp_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_pipe
        logic [7:0] stage [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= OPM_HOLD;
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/dsp_mac_sched.sv
// Two-requester round-robin scheduler driving one DSP48A1 slice as a multiply-accumulate engine.
module dsp_mac_sched
    import dsp_sched_pkg::*;
#(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned PWIDTH = 48,
    parameter int unsigned LW     = 8,
    parameter int unsigned LAT    = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        REQ,
    input  logic [2*LW-1:0]   LEN,
    input  logic [1:0]        OP_VALID,
    input  logic [PWIDTH-1:0] P_IN,
    output logic [1:0]        GNT,
    output logic [1:0]        OP_READY,
    output logic              SEL,
    output logic              CE_AB,
    output logic [7:0]        OPMODE,
    output logic [PWIDTH-1:0] RESULT,
    output logic              DONE,
    output logic              DONE_ID
);

    if (PWIDTH < 2 * WIDTH) begin : g_width_check
        $error("PWIDTH is too narrow for WIDTH x WIDTH products");
    end

    state_e        state;
    logic          prio;
    logic [LW-1:0] cnt;
    logic [LW-1:0] len_q;
    logic          g_new;
    logic [LW-1:0] len_new;
    logic          accept;
    logic [7:0]    code;

    always_comb begin
        g_new   = REQ[prio] ? prio : ~prio;
        len_new = g_new ? LEN[2*LW-1:LW] : LEN[LW-1:0];
        accept  = OP_VALID[SEL] & OP_READY[SEL];
        CE_AB   = accept;
        code    = OPM_HOLD;
        if (state == StRun && accept) begin
            code = (cnt == '0) ? OPM_MUL : OPM_MAC;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= StIdle;
            prio     <= 1'b0;
            cnt      <= '0;
            len_q    <= '0;
            GNT      <= 2'b00;
            OP_READY <= 2'b00;
            SEL      <= 1'b0;
            RESULT   <= '0;
            DONE     <= 1'b0;
            DONE_ID  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (|REQ) begin
                        SEL   <= g_new;
                        GNT   <= 2'b01 << g_new;
                        prio  <= ~g_new;
                        len_q <= len_new;
                        cnt   <= '0;
                        if (len_new == '0) begin
                            state <= StFin;
                        end else begin
                            state    <= StRun;
                            OP_READY <= 2'b01 << g_new;
                        end
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (cnt + LW'(1) == len_q) begin
                            state    <= StDrain;
                            OP_READY <= 2'b00;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + LW'(1);
                        end
                    end
                end
                StDrain: begin
                    // Wait for the last product to pass the A/B, M and P registers
                    if (cnt == LW'(LAT - 1)) begin
                        state <= StFin;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + LW'(1);
                    end
                end
                StFin: begin
                    RESULT  <= (len_q == '0) ? '0 : P_IN;
                    DONE    <= 1'b1;
                    DONE_ID <= SEL;
                    GNT     <= 2'b00;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    opm_pipe #(
        .DEPTH(LAT - 1)
    ) u_opm_pipe (
        .clk  (CLK),
        .rst  (RST),
        .din  (code),
        .dout (OPMODE)
    );

endmodule

// File: tb/tb_dsp_mac_sched.sv
// Table-driven bench for dsp_mac_sched with a behavioural DSP48A1 model and a result scoreboard.
module tb_dsp_mac_sched;

    localparam int LW  = 8;
    localparam int W   = 18;
    localparam int PW  = 48;
    localparam int LAT = 3;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [1:0]      REQ = 2'b00;
    logic [2*LW-1:0] LEN = '0;
    logic [1:0]      OP_VALID = 2'b00;
    logic [PW-1:0]   P_IN;
    logic [1:0]      GNT, OP_READY;
    logic            SEL, CE_AB, DONE, DONE_ID;
    logic [7:0]      OPMODE;
    logic [PW-1:0]   RESULT;

    logic [W-1:0]    opa [2];
    logic [W-1:0]    opb [2];

    dsp_mac_sched #(
        .WIDTH (W),
        .PWIDTH(PW),
        .LW    (LW),
        .LAT   (LAT)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .LEN     (LEN),
        .OP_VALID(OP_VALID),
        .P_IN    (P_IN),
        .GNT     (GNT),
        .OP_READY(OP_READY),
        .SEL     (SEL),
        .CE_AB   (CE_AB),
        .OPMODE  (OPMODE),
        .RESULT  (RESULT),
        .DONE    (DONE),
        .DONE_ID (DONE_ID)
    );

    always #5 CLK = ~CLK;

    // Behavioural DSP48A1: A/B reg (CE_AB), M reg, P reg steered by OPMODE
    logic [W-1:0]   ar, br;
    logic [2*W-1:0] m;
    logic [PW-1:0]  p;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ar <= '0; br <= '0; m <= '0; p <= '0;
        end else begin
            if (CE_AB) begin
                ar <= opa[SEL];
                br <= opb[SEL];
            end
            m <= ar * br;
            case (OPMODE)
                8'h01:   p <= PW'(m);
                8'h09:   p <= p + PW'(m);
                default: p <= p;
            endcase
        end
    end
    assign P_IN = p;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned done_cyc = 0;
    logic [7:0]  opm_at [256];
    bit          rdy_seen = 1'b0;

    typedef struct {
        logic [1:0]    id;
        logic [PW-1:0] res;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    typedef struct {
        logic [1:0]    req;
        logic [LW-1:0] l0;
        logic [LW-1:0] l1;
        logic [7:0]    vpat;
        logic [W-1:0]  a0;
        logic [W-1:0]  b0;
        logic [W-1:0]  astep;
        int            exp_g;
        logic [PW-1:0] exp_res;
        int            exp_lat;
        bit            opm_chk;
        logic [71:0]   opm_exp;
    } vec_t;
    vec_t tbl [7];
    vec_t hv;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        opm_at[cyc[7:0]] <= OPMODE;
        if (OP_READY != 2'b00) rdy_seen = 1'b1;
    end

    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            done_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got DONE with DONE_ID=%0d, required no DONE", DONE_ID);
            end else begin
                e = sb.pop_front();
                if (RESULT !== e.res || DONE_ID !== e.id[0]) begin
                    errors++;
                    $display("FAIL done_result: got RESULT=%0d DONE_ID=%0d, required RESULT=%0d DONE_ID=%0d",
                             RESULT, DONE_ID, e.res, e.id[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input bit keep_req);
        int unsigned req_c, g_c;
        int          g, k, i, n;
        bit          other_rdy;
        logic [71:0] got;
        @(negedge CLK);
        REQ      = v.req;
        LEN      = {v.l1, v.l0};
        req_c    = cyc;
        rdy_seen = 1'b0;
        i = 0;
        while (GNT == 2'b00 && i < 20) begin
            @(negedge CLK);
            i++;
        end
        chk("grant", 72'(GNT), 72'(2'b01 << v.exp_g));
        g_c = cyc;
        if (!keep_req) REQ = 2'b00;
        g = GNT[1] ? 1 : 0;
        n = g ? int'(v.l1) : int'(v.l0);
        sb.push_back('{id: 2'(v.exp_g), res: v.exp_res});
        k = 0;
        i = 0;
        other_rdy = 1'b0;
        while (k < n && i < 200) begin
            opa[g]        = v.a0 + W'(k) * v.astep;
            opb[g]        = v.b0;
            opa[1-g]      = 18'h2abcd;
            opb[1-g]      = 18'h1f0f0;
            OP_VALID[g]   = v.vpat[i % 8];
            OP_VALID[1-g] = 1'b1;
            if (OP_READY[1-g]) other_rdy = 1'b1;
            if (OP_READY[g] && OP_VALID[g]) k++;
            i++;
            @(negedge CLK);
        end
        OP_VALID = 2'b00;
        chk("other_ready_low", 72'(other_rdy), 72'(0));
        chk("beats_accepted", 72'(k), 72'(n));
        i = 0;
        while (sb.size() != 0 && i < 50) begin
            @(negedge CLK);
            i++;
        end
        chk("done_seen", 72'(sb.size()), 72'(0));
        sb.delete();
        @(negedge CLK);
        if (n == 0) chk("no_ready_len0", 72'(rdy_seen), 72'(0));
        if (v.exp_lat != 0) chk("done_latency", 72'(done_cyc - req_c), 72'(v.exp_lat));
        if (v.opm_chk) begin
            got = '0;
            for (int j = 0; j < 9; j++) got = {got[63:0], opm_at[8'(g_c + j)]};
            chk("opmode_seq", got, v.opm_exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        opa[0] = '0; opa[1] = '0; opb[0] = '0; opb[1] = '0;
        //        req    l0  l1  vpat          a0        b0        step   g  result          lat opm opmode sequence from grant
        tbl[0] = '{2'b01, 4, 0, 8'hff,       18'd2,    18'd3,    18'd0,    0, 48'd24,          9, 1, 72'h08_08_01_09_09_09_08_08_08};
        tbl[1] = '{2'b11, 2, 2, 8'hff,       18'd5,    18'd7,    18'd1,    1, 48'd77,          7, 0, 72'h0};
        tbl[2] = '{2'b11, 2, 2, 8'hff,       18'd5,    18'd7,    18'd1,    0, 48'd77,          7, 0, 72'h0};
        tbl[3] = '{2'b01, 3, 0, 8'b00010101, 18'd4,    18'd10,   18'd1,    0, 48'd150,         0, 1, 72'h08_08_01_08_09_08_09_08_08};
        tbl[4] = '{2'b10, 0, 0, 8'hff,       18'd9,    18'd9,    18'd0,    1, 48'd0,           2, 0, 72'h0};
        tbl[5] = '{2'b10, 0, 5, 8'b11011011, 18'd1000, 18'd1000, 18'd1000, 1, 48'd15000000,    0, 0, 72'h0};
        tbl[6] = '{2'b01, 1, 0, 8'hff,       18'h3ffff, 18'h3ffff, 18'd0,  0, 48'd68718952449, 6, 0, 72'h0};

        #1 RST = 1'b1;
        #1 chk("reset_outputs", {GNT, OP_READY, SEL, CE_AB, OPMODE, RESULT, DONE, DONE_ID},
               {2'b00, 2'b00, 1'b0, 1'b0, 8'h08, 48'h0, 1'b0, 1'b0});
        repeat (2) @(negedge CLK);
        chk("reset_held", {GNT, OP_READY, OPMODE, RESULT, DONE}, {2'b00, 2'b00, 8'h08, 48'h0, 1'b0});
        RST = 1'b0;

        for (int t = 0; t < 7; t++) run_job(tbl[t], 1'b0);

        // REQ held on both: grant alternates job to job with no idle gap
        hv = '{2'b11, 1, 1, 8'hff, 18'd7, 18'd8, 18'd0, 1, 48'd56, 6, 0, 72'h0};
        run_job(hv, 1'b1);
        hv.exp_g   = 0;
        hv.exp_lat = 0;
        run_job(hv, 1'b0);

        // Reset in the middle of a job: outputs clear at once and no DONE follows
        @(negedge CLK);
        REQ = 2'b01;
        LEN = {8'd0, 8'd6};
        for (int i = 0; i < 20 && GNT == 2'b00; i++) @(negedge CLK);
        REQ         = 2'b00;
        opa[0]      = 18'd9;
        opb[0]      = 18'd9;
        OP_VALID[0] = 1'b1;
        repeat (2) @(negedge CLK);
        chk("mid_job_running", 72'(GNT), 72'(2'b01));
        #2 RST = 1'b1;
        #1 chk("reset_mid_job", {GNT, OP_READY, SEL, CE_AB, OPMODE, RESULT, DONE, DONE_ID},
               {2'b00, 2'b00, 1'b0, 1'b0, 8'h08, 48'h0, 1'b0, 1'b0});
        repeat (2) @(negedge CLK);
        RST      = 1'b0;
        OP_VALID = 2'b00;
        repeat (8) @(negedge CLK);

        // Round-robin pointer cleared by reset: requester 0 wins again
        hv = '{2'b11, 2, 2, 8'hff, 18'd3, 18'd3, 18'd0, 0, 48'd18, 7, 0, 72'h0};
        run_job(hv, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
